data_io_upload: RTL and testbench
=================================

// Module: data_io_upload
// PURPOSE
//  FPGA->ARM upload path for the MiST io-controller SPI link (SS2 command channel), the
//  counterpart of the ARM->FPGA download path. Streams core memory (save RAM, savestates)
//  to the ARM as little-endian bytes, fetching 16-bit words through a req/ack read port.
//  SPI pins are oversampled in clk_sys; no logic runs on SPI_SCK.
// PARAMETERS
//  AW            25     ioctl_addr width
//  SYNC_STAGES   2      synchroniser depth on SPI_SCK/SPI_SS2/SPI_DI (>=2)
//  UNDERRUN_BYTE 8'h00  byte shifted out when no word is ready
// PORTS
//  clk_sys         in   1   system clock; must be >= 4x SPI_SCK
//  reset_n         in   1   asynchronous active-low reset
//  SPI_SCK         in   1   SPI clock from ARM (mode 0)
//  SPI_SS2         in   1   chip select, active low
//  SPI_DI          in   1   MOSI
//  spi_do          out  1   MISO data
//  spi_do_oe       out  1   MISO drive enable (top level tristates when 0)
//  ioctl_upload    out  1   upload session active
//  ioctl_index     out  8   menu index (cmd 0x55)
//  ioctl_addr      out  AW  byte address of requested word (always even)
//  ioctl_rd        out  1   read request, held until ack
//  ioctl_rd_ack    in   1   1-cycle ack; ioctl_din valid in the same cycle
//  ioctl_din       in   16  read data; [7:0] sent first, then [15:8]
//  ioctl_underrun  out  1   sticky: a byte was sent as UNDERRUN_BYTE; cleared on upload start
// BEHAVIOUR
//  Reset: spi_do=1, spi_do_oe=0, ioctl_upload=0, ioctl_index=0, ioctl_addr=0, ioctl_rd=0,
//   ioctl_underrun=0; FSMs in S_IDLE / F_EMPTY.
//  Front end: SCK/SS2/DI synchronised; rise = SCK edge detect sampled DI, fall = shift out.
//  Bits MSB first; bit counter 0..7 cleared while SS2 high. SS2 rise mid-byte drops the
//   partial byte; an upload byte is consumed only after its 8th rise.
//  Frame FSM: S_IDLE -(SS2 fall)-> S_CMD; 8th rise latches cmd -> S_ARG or S_TX;
//   any state -(SS2 high)-> S_IDLE.
//   0x53 FILE_TX, first arg byte: 0xAA -> ioctl_upload=1, ioctl_addr=0, buffer flushed,
//     byte phase=lo, underrun cleared; 0x00 -> ioctl_upload=0, ioctl_rd dropped;
//     other values ignored. Bytes after first arg ignored.
//   0x55 FILE_INDEX: first arg byte -> ioctl_index. 0x57 FILE_RX_DAT: -> S_TX.
//   Unknown cmd: all bytes ignored, spi_do_oe=0.
//  S_TX: spi_do_oe=1 for the whole frame. On the fall after the cmd byte's 8th rise (and after
//   each data byte's 8th rise) shifter loads next byte; its MSB is on spi_do from that fall.
//   Next byte = buf[7:0] (phase lo) or buf[15:8] (phase hi); phase toggles after byte is consumed;
//   after hi byte is consumed buffer is marked empty.
//   If buffer empty or ioctl_upload=0 at load: send UNDERRUN_BYTE, set ioctl_underrun,
//   phase and address unchanged.
//  Fetch FSM: F_EMPTY -(ioctl_upload)-> F_REQ (ioctl_rd=1) -(ack)-> F_FULL: buf<=ioctl_din,
//   ioctl_addr+=2 (wraps mod 2^AW). F_FULL -> F_EMPTY when hi byte consumed. Request latency
//   may span SPI frames; buffer and phase persist across frames while ioctl_upload=1.
//  Upload stop while ioctl_rd=1: ioctl_rd drops next cycle; a late ack is ignored.
//  Upload start (0xAA) while already active restarts from address 0.
//  Async reset mid-frame: outputs to reset values; next frame begins in S_IDLE.
// CONFIGURATION
//  DATA_IO_UPLOAD_CHECKSUM_EN defined: adds output ioctl_upload_sum[7:0] = mod-256 sum of
//   every non-underrun byte consumed in S_TX, cleared on upload start (0xAA).
//  Undefined: port absent, no adder logic; all other behaviour identical.
// TESTING
//  T1 reset_n=0 mid S_TX -> spi_do_oe=0, ioctl_upload=0, ioctl_rd=0 within 1 clk_sys.
//  T2 0x55,0x03 -> ioctl_index=0x03; 0x53,0xAA -> ioctl_upload=1, ioctl_rd=1, ioctl_addr=0.
//  T3 mem {0:0x2211,2:0x4433}, ack 3 cycles -> 0x57 frame MISO = 11 22 33 44, ioctl_addr=4.
//  T4 ack withheld for 40 SCKs -> first RX_DAT byte 0x00, ioctl_underrun=1, next byte = 0x11.
//  T5 SS2 rise after 4 bits of byte 0x22, new 0x57 frame -> 0x22 resent, then 0x33.
//  T6 CHECKSUM_EN: bytes 11 22 33 44 -> ioctl_upload_sum=0xAA; 0x53,0xAA -> 0x00.

Source files
------------

// File: rtl/data_io_upload.sv
// data_io_upload: FPGA->ARM upload path on the SS2 SPI command channel.
// SPI pins are oversampled in clk_sys; 16-bit memory words are fetched through
// ioctl_rd/ioctl_rd_ack and streamed to the ARM low byte first, MSB first per byte.
// Optional define DATA_IO_UPLOAD_CHECKSUM_EN adds ioctl_upload_sum (mod-256 byte sum).

module data_io_upload #(
    parameter int         AW            = 25,
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] UNDERRUN_BYTE = 8'h00
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          SPI_SCK,
    input  logic          SPI_SS2,
    input  logic          SPI_DI,
    output logic          spi_do,
    output logic          spi_do_oe,
    output logic          ioctl_upload,
    output logic [7:0]    ioctl_index,
    output logic [AW-1:0] ioctl_addr,
    output logic          ioctl_rd,
    input  logic          ioctl_rd_ack,
    input  logic [15:0]   ioctl_din,
    output logic          ioctl_underrun
`ifdef DATA_IO_UPLOAD_CHECKSUM_EN
    ,
    output logic [7:0]    ioctl_upload_sum
`endif
);

    localparam logic [7:0] CMD_FILE_TX     = 8'h53;
    localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;
    localparam logic [7:0] CMD_FILE_RX_DAT = 8'h57;
    localparam logic [7:0] ARG_START       = 8'hAA;
    localparam logic [7:0] ARG_STOP        = 8'h00;

    // S_SKIP swallows every byte that carries no meaning (unknown cmd, extra args)
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ARG,
        S_TX,
        S_SKIP
    } frame_state_t;

    typedef enum logic [1:0] {
        F_EMPTY,
        F_REQ,
        F_FULL
    } fetch_state_t;

    // synchroniser chains and SCK edge history
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ss2_sync_q, ss2_sync_d;
    logic [SYNC_STAGES-1:0] di_sync_q,  di_sync_d;
    logic                   sck_prev_q, sck_prev_d;

    // receive side
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [6:0]   rx_shift_q, rx_shift_d;

    // frame decoder
    frame_state_t state_q, state_d;
    logic [7:0]   cmd_q, cmd_d;
    logic [7:0]   index_q, index_d;
    logic         upload_q, upload_d;

    // transmit side
    logic [7:0]   tx_shift_q, tx_shift_d;
    logic         load_pend_q, load_pend_d;
    logic         tx_valid_q, tx_valid_d;
    logic         phase_q, phase_d;
    logic         underrun_q, underrun_d;

    // word fetch
    fetch_state_t fetch_q, fetch_d;
    logic [15:0]  buf_q, buf_d;
    logic [AW-1:0] addr_q, addr_d;

    // decoded strobes
    logic         sck_s, ss2_s, di_s;
    logic         rise, fall;
    logic         byte_done;
    logic [7:0]   rx_byte;
    logic         start_evt, stop_evt, load_req, consume;
    logic         buf_ready;
    logic [7:0]   cur_byte;

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign ss2_s     = ss2_sync_q[SYNC_STAGES-1];
    assign di_s      = di_sync_q[SYNC_STAGES-1];
    assign rise      = sck_s & ~sck_prev_q;
    assign fall      = ~sck_s & sck_prev_q;
    assign byte_done = rise & ~ss2_s & (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_shift_q, di_s};
    assign buf_ready = (fetch_q == F_FULL) & upload_q;
    assign cur_byte  = phase_q ? buf_q[15:8] : buf_q[7:0];

    // shift the raw SPI pins through the synchroniser chains
    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
        ss2_sync_d = {ss2_sync_q[SYNC_STAGES-2:0], SPI_SS2};
        di_sync_d  = {di_sync_q[SYNC_STAGES-2:0],  SPI_DI};
        sck_prev_d = sck_s;
    end

    // bit counter and MOSI shifter; a deselect mid-byte throws the partial byte away
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        if (ss2_s) begin
            bit_cnt_d = 3'd0;
        end else if (rise) begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            rx_shift_d = {rx_shift_q[5:0], di_s};
        end
    end

    // frame decoder: command byte, first argument byte, and data-phase byte strobes
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        index_d   = index_q;
        upload_d  = upload_q;
        start_evt = 1'b0;
        stop_evt  = 1'b0;
        load_req  = 1'b0;
        consume   = 1'b0;
        if (ss2_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_CMD;
                end
                S_CMD: begin
                    if (byte_done) begin
                        cmd_d = rx_byte;
                        if (rx_byte == CMD_FILE_TX || rx_byte == CMD_FILE_INDEX) begin
                            state_d = S_ARG;
                        end else if (rx_byte == CMD_FILE_RX_DAT) begin
                            state_d  = S_TX;
                            load_req = 1'b1;
                        end else begin
                            state_d = S_SKIP;
                        end
                    end
                end
                S_ARG: begin
                    if (byte_done) begin
                        state_d = S_SKIP;
                        if (cmd_q == CMD_FILE_TX) begin
                            if (rx_byte == ARG_START) begin
                                start_evt = 1'b1;
                                upload_d  = 1'b1;
                            end else if (rx_byte == ARG_STOP) begin
                                stop_evt = 1'b1;
                                upload_d = 1'b0;
                            end
                        end else begin
                            index_d = rx_byte;
                        end
                    end
                end
                S_TX: begin
                    if (byte_done) begin
                        load_req = 1'b1;
                        consume  = tx_valid_q;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // MISO shifter: load the next byte on the fall after a byte boundary, else shift
    always_comb begin
        tx_shift_d  = tx_shift_q;
        load_pend_d = load_pend_q;
        tx_valid_d  = tx_valid_q;
        phase_d     = phase_q;
        underrun_d  = underrun_q;
        if (start_evt) begin
            phase_d    = 1'b0;
            underrun_d = 1'b0;
        end
        if (ss2_s) begin
            load_pend_d = 1'b0;
            tx_valid_d  = 1'b0;
        end else begin
            if (consume) begin
                phase_d    = ~phase_q;
                tx_valid_d = 1'b0;
            end
            if (load_req) begin
                load_pend_d = 1'b1;
            end
            if (fall) begin
                if (load_pend_q) begin
                    load_pend_d = 1'b0;
                    if (buf_ready) begin
                        tx_shift_d = cur_byte;
                        tx_valid_d = 1'b1;
                    end else begin
                        tx_shift_d = UNDERRUN_BYTE;
                        tx_valid_d = 1'b0;
                        underrun_d = 1'b1;
                    end
                end else begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b1};
                end
            end
        end
    end

    // single-word fetch buffer; refilled as soon as its high byte has gone out
    always_comb begin
        fetch_d = fetch_q;
        buf_d   = buf_q;
        addr_d  = addr_q;
        if (start_evt) begin
            fetch_d = F_EMPTY;
            addr_d  = '0;
        end else if (stop_evt || !upload_q) begin
            fetch_d = F_EMPTY;
        end else begin
            case (fetch_q)
                F_EMPTY: begin
                    fetch_d = F_REQ;
                end
                F_REQ: begin
                    if (ioctl_rd_ack) begin
                        buf_d   = ioctl_din;
                        addr_d  = addr_q + AW'(2);
                        fetch_d = F_FULL;
                    end
                end
                F_FULL: begin
                    if (consume && phase_q) begin
                        fetch_d = F_EMPTY;
                    end
                end
                default: begin
                    fetch_d = F_EMPTY;
                end
            endcase
        end
    end

    // synchroniser and receive registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q <= '0;
            ss2_sync_q <= '1;
            di_sync_q  <= '0;
            sck_prev_q <= 1'b0;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 7'd0;
        end else begin
            sck_sync_q <= sck_sync_d;
            ss2_sync_q <= ss2_sync_d;
            di_sync_q  <= di_sync_d;
            sck_prev_q <= sck_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // frame decoder registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cmd_q    <= 8'd0;
            index_q  <= 8'd0;
            upload_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            index_q  <= index_d;
            upload_q <= upload_d;
        end
    end

    // transmit registers; the shifter resets to all ones so MISO idles high
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tx_shift_q  <= 8'hFF;
            load_pend_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            phase_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            tx_shift_q  <= tx_shift_d;
            load_pend_q <= load_pend_d;
            tx_valid_q  <= tx_valid_d;
            phase_q     <= phase_d;
            underrun_q  <= underrun_d;
        end
    end

    // fetch registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            fetch_q <= F_EMPTY;
            buf_q   <= 16'd0;
            addr_q  <= '0;
        end else begin
            fetch_q <= fetch_d;
            buf_q   <= buf_d;
            addr_q  <= addr_d;
        end
    end

`ifdef DATA_IO_UPLOAD_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // running sum of every real (non-underrun) byte the ARM has consumed
    always_comb begin
        sum_d = sum_q;
        if (start_evt) begin
            sum_d = 8'd0;
        end else if (consume) begin
            sum_d = sum_q + cur_byte;
        end
    end

    // checksum register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= 8'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign ioctl_upload_sum = sum_q;
`endif

    assign spi_do         = tx_shift_q[7];
    assign spi_do_oe      = (state_q == S_TX);
    assign ioctl_upload   = upload_q;
    assign ioctl_index    = index_q;
    assign ioctl_addr     = addr_q;
    assign ioctl_rd       = (fetch_q == F_REQ);
    assign ioctl_underrun = underrun_q;

endmodule

// File: tb/tb_data_io_upload.sv
// tb_data_io_upload: drives the ARM side of the SS2 link, models the memory read port,
// and checks every MISO byte against a byte-stream model of the uploaded memory.

`timescale 1ns/1ps

module tb_data_io_upload;

    localparam int         AW   = 25;
    localparam int         HALF = 10;
    localparam logic [7:0] UNDR = 8'h00;

    logic          clk_sys;
    logic          reset_n;
    logic          SPI_SCK;
    logic          SPI_SS2;
    logic          SPI_DI;
    logic          spi_do;
    logic          spi_do_oe;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic [AW-1:0] ioctl_addr;
    logic          ioctl_rd;
    logic          ioctl_rd_ack;
    logic [15:0]   ioctl_din;
    logic          ioctl_underrun;
`ifdef DATA_IO_UPLOAD_CHECKSUM_EN
    logic [7:0]    ioctl_upload_sum;
`endif

    data_io_upload #(
        .AW(AW),
        .SYNC_STAGES(2),
        .UNDERRUN_BYTE(UNDR)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .SPI_SCK(SPI_SCK),
        .SPI_SS2(SPI_SS2),
        .SPI_DI(SPI_DI),
        .spi_do(spi_do),
        .spi_do_oe(spi_do_oe),
        .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index),
        .ioctl_addr(ioctl_addr),
        .ioctl_rd(ioctl_rd),
        .ioctl_rd_ack(ioctl_rd_ack),
        .ioctl_din(ioctl_din),
        .ioctl_underrun(ioctl_underrun)
`ifdef DATA_IO_UPLOAD_CHECKSUM_EN
        ,
        .ioctl_upload_sum(ioctl_upload_sum)
`endif
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] mem [64];

    int          model_ptr    = 0;
    logic [7:0]  model_sum    = 8'd0;
    logic        model_upload = 1'b0;
    logic [7:0]  model_index  = 8'd0;

    int          ack_latency  = 3;
    logic        hold_ack     = 1'b0;
    logic        late_ack_req = 1'b0;
    int          rd_cycles    = 0;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] stream_byte(input int k);
        logic [15:0] w;
        w = mem[(k >> 1) % 64];
        return (k % 2 == 1) ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [31:0] model_addr();
        return 32'((2 * (model_ptr / 2 + 1)) % (1 << AW));
    endfunction

    task automatic half_period();
        repeat (HALF) @(negedge clk_sys);
    endtask

    task automatic ss_low();
        SPI_SS2 = 1'b0;
        half_period();
    endtask

    task automatic ss_high();
        half_period();
        SPI_SS2 = 1'b1;
        half_period();
        half_period();
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            SPI_DI = b[7-i];
            half_period();
            SPI_SCK = 1'b1;
            half_period();
            SPI_SCK = 1'b0;
        end
    endtask

    task automatic model_start();
        model_upload = 1'b1;
        model_ptr    = 0;
        model_sum    = 8'd0;
    endtask

    task automatic apply_stimulus(input logic [7:0] cmd, input logic [7:0] arg);
        ss_low();
        spi_byte(cmd, 8);
        spi_byte(arg, 8);
        ss_high();
        if (cmd == 8'h53 && arg == 8'hAA) model_start();
        if (cmd == 8'h53 && arg == 8'h00) model_upload = 1'b0;
        if (cmd == 8'h55) model_index = arg;
    endtask

    // RX_DAT frame: full bytes come from the model stream (or underrun), then an optional partial byte
    task automatic rx_frame(input int nbytes, input int partial_bits, input logic underrun);
        ss_low();
        spi_byte(8'h57, 8);
        for (int i = 0; i < nbytes; i++) begin
            if (underrun) begin
                exp_q.push_back(UNDR);
            end else begin
                exp_q.push_back(stream_byte(model_ptr));
                model_sum = model_sum + stream_byte(model_ptr);
                model_ptr++;
            end
            spi_byte(8'($urandom), 8);
        end
        if (partial_bits > 0) spi_byte(8'($urandom), partial_bits);
        ss_high();
    endtask

    // memory read port: ack after ack_latency cycles of ioctl_rd, or a forced stray ack
    initial begin
        ioctl_rd_ack = 1'b0;
        ioctl_din    = 16'h0000;
        forever begin
            @(posedge clk_sys);
            #1;
            ioctl_rd_ack = 1'b0;
            if (late_ack_req) begin
                ioctl_rd_ack = 1'b1;
                ioctl_din    = 16'hDEAD;
                late_ack_req = 1'b0;
                rd_cycles    = 0;
            end else if (ioctl_rd && !hold_ack) begin
                rd_cycles++;
                if (rd_cycles >= ack_latency) begin
                    ioctl_rd_ack = 1'b1;
                    ioctl_din    = mem[ioctl_addr[6:1]];
                    rd_cycles    = 0;
                end
            end else begin
                rd_cycles = 0;
            end
        end
    end

    // MISO monitor: assembles bytes while the DUT drives MISO and scores them
    initial begin
        int         mon_bits;
        logic [7:0] mon_sh;
        logic [7:0] exp_b;
        mon_bits = 0;
        mon_sh   = 8'd0;
        forever begin
            @(posedge SPI_SCK or posedge SPI_SS2);
            if (SPI_SS2) begin
                mon_bits = 0;
            end else if (spi_do_oe) begin
                mon_sh = {mon_sh[6:0], spi_do};
                mon_bits++;
                if (mon_bits == 8) begin
                    mon_bits = 0;
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL miso_unexpected: got 0x%0h, expected no byte", mon_sh);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check_output("miso_byte", 32'(mon_sh), 32'(exp_b));
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h2211;
        mem[1] = 16'h4433;
        SPI_SCK = 1'b0;
        SPI_SS2 = 1'b1;
        SPI_DI  = 1'b0;
        reset_n = 1'b0;
        repeat (5) @(negedge clk_sys);
        check_output("rst_spi_do",    32'(spi_do), 32'd1);
        check_output("rst_oe",        32'(spi_do_oe), 32'd0);
        check_output("rst_upload",    32'(ioctl_upload), 32'd0);
        check_output("rst_index",     32'(ioctl_index), 32'd0);
        check_output("rst_addr",      32'(ioctl_addr), 32'd0);
        check_output("rst_rd",        32'(ioctl_rd), 32'd0);
        check_output("rst_underrun",  32'(ioctl_underrun), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);

        // index command and upload start
        apply_stimulus(8'h55, 8'h03);
        check_output("index_set", 32'(ioctl_index), 32'h03);
        hold_ack = 1'b1;
        apply_stimulus(8'h53, 8'hAA);
        check_output("start_upload", 32'(ioctl_upload), 32'd1);
        check_output("start_rd",     32'(ioctl_rd), 32'd1);
        check_output("start_addr",   32'(ioctl_addr), 32'd0);
        hold_ack    = 1'b0;
        ack_latency = 3;
        repeat (30) @(negedge clk_sys);

        // four bytes; the request for the third word is withheld to observe it
        ss_low();
        spi_byte(8'h57, 8);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) hold_ack = 1'b1;
            exp_q.push_back(stream_byte(model_ptr));
            model_sum = model_sum + stream_byte(model_ptr);
            model_ptr++;
            spi_byte(8'h00, 8);
        end
        ss_high();
        check_output("pending_rd",   32'(ioctl_rd), 32'd1);
        check_output("pending_addr", 32'(ioctl_addr), 32'd4);

        // restart while the read is withheld: underrun then recovery
        apply_stimulus(8'h53, 8'hAA);
        check_output("restart_addr",     32'(ioctl_addr), 32'd0);
        check_output("restart_rd",       32'(ioctl_rd), 32'd1);
        check_output("restart_underrun", 32'(ioctl_underrun), 32'd0);
        rx_frame(1, 0, 1'b1);
        repeat (24) begin half_period(); half_period(); end
        check_output("underrun_flag", 32'(ioctl_underrun), 32'd1);
        check_output("underrun_addr", 32'(ioctl_addr), 32'd0);
        hold_ack = 1'b0;
        repeat (30) @(negedge clk_sys);
        check_output("refill_addr", 32'(ioctl_addr), model_addr());
        rx_frame(2, 4, 1'b0);
        rx_frame(2, 0, 1'b0);
        repeat (30) @(negedge clk_sys);
        check_output("stream_addr", 32'(ioctl_addr), model_addr());
`ifdef DATA_IO_UPLOAD_CHECKSUM_EN
        check_output("sum_bytes", 32'(ioctl_upload_sum), 32'hAA);
`endif

        // stop while a read is outstanding; a stray ack afterwards must be ignored
        hold_ack = 1'b1;
        apply_stimulus(8'h53, 8'hAA);
`ifdef DATA_IO_UPLOAD_CHECKSUM_EN
        check_output("sum_cleared", 32'(ioctl_upload_sum), 32'h00);
`endif
        check_output("stop_pre_rd", 32'(ioctl_rd), 32'd1);
        apply_stimulus(8'h53, 8'h00);
        check_output("stop_upload", 32'(ioctl_upload), 32'd0);
        check_output("stop_rd",     32'(ioctl_rd), 32'd0);
        late_ack_req = 1'b1;
        repeat (5) @(negedge clk_sys);
        check_output("late_ack_addr", 32'(ioctl_addr), 32'd0);
        hold_ack = 1'b0;
        repeat (10) @(negedge clk_sys);
        check_output("stopped_rd", 32'(ioctl_rd), 32'd0);
        rx_frame(1, 0, 1'b1);
        check_output("stopped_underrun", 32'(ioctl_underrun), 32'd1);

        // unknown command: MISO stays undriven
        ss_low();
        spi_byte(8'hA5, 8);
        spi_byte(8'h5A, 4);
        check_output("unknown_oe", 32'(spi_do_oe), 32'd0);
        spi_byte(8'h5A, 4);
        ss_high();

        // randomized session
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        apply_stimulus(8'h53, 8'hAA);
        repeat (30) @(negedge clk_sys);
        for (int it = 0; it < 16; it++) begin
            int r;
            r = $urandom_range(0, 9);
            ack_latency = $urandom_range(1, 4);
            if (r < 7) begin
                rx_frame($urandom_range(1, 6),
                         ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0, 1'b0);
            end else if (r == 7) begin
                apply_stimulus(8'h55, 8'($urandom));
                check_output("rand_index", 32'(ioctl_index), 32'(model_index));
            end else if (r == 8) begin
                ss_low();
                spi_byte(8'hA5, 8);
                spi_byte(8'($urandom), 8);
                ss_high();
            end else begin
                apply_stimulus(8'h53, 8'hAA);
            end
            repeat (30) @(negedge clk_sys);
            check_output("rand_addr",     32'(ioctl_addr), model_addr());
            check_output("rand_rd",       32'(ioctl_rd), 32'd0);
            check_output("rand_underrun", 32'(ioctl_underrun), 32'd0);
`ifdef DATA_IO_UPLOAD_CHECKSUM_EN
            check_output("rand_sum", 32'(ioctl_upload_sum), 32'(model_sum));
`endif
        end

        // asynchronous reset in the middle of a data byte
        ss_low();
        spi_byte(8'h57, 8);
        spi_byte(8'h00, 3);
        reset_n = 1'b0;
        #1;
        check_output("t1_oe",     32'(spi_do_oe), 32'd0);
        check_output("t1_upload", 32'(ioctl_upload), 32'd0);
        check_output("t1_rd",     32'(ioctl_rd), 32'd0);
        check_output("t1_spi_do", 32'(spi_do), 32'd1);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;
        ss_high();
        model_upload = 1'b0;
        apply_stimulus(8'h55, 8'h5A);
        check_output("post_reset_index", 32'(ioctl_index), 32'h5A);

        repeat (20) @(negedge clk_sys);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
